// File: rtl/core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// core_seq_ctrl
//   Instruction sequencer for one convolution tile job. Emits the core's
//   34-bit inst word plus mode/sel. A job runs: weight preload (LOAD_W),
//   array settle gap (SETTLE), activation streaming (EXEC), then draining
//   the output FIFO into psum memory (DRAIN), and a one-cycle DONE.
//
// Ports
//   clk          clock
//   reset        synchronous, active-low reset
//   start        one-cycle job request, honoured only when idle
//   cfg_nij      activation vectors per job (0 = empty job)
//   cfg_w_base   xmem address of first weight row
//   cfg_x_base   xmem address of first activation
//   cfg_p_base   pmem address of first output
//   cfg_mode     0: 2-bit, 1: 4-bit (latched at start)
//   cfg_acc      value of inst[33] during DRAIN (latched at start)
//   cfg_pingpong 1: toggle sel after each completed job
//   ofifo_valid  core output FIFO holds data
//   inst         registered instruction word to core
//   mode         latched cfg_mode
//   sel          output bank select
//   busy         job in progress
//   done         one-cycle pulse at job end
//   err_timeout  sticky drain-timeout flag, cleared by next accepted start
// ---------------------------------------------------------------------------
module core_seq_ctrl #(
  parameter int ROW     = 2,
  parameter int COL     = 2,
  parameter int ADDR_W  = 11,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     cfg_nij,
  input  logic [ADDR_W-1:0]     cfg_w_base,
  input  logic [ADDR_W-1:0]     cfg_x_base,
  input  logic [ADDR_W-1:0]     cfg_p_base,
  input  logic                  cfg_mode,
  input  logic                  cfg_acc,
  input  logic                  cfg_pingpong,
  input  logic                  ofifo_valid,
  output logic [2*ADDR_W+11:0]  inst,
  output logic                  mode,
  output logic                  sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  // The settle gap never drops below the array's diagonal skew.
  localparam int MIN_SETTLE = ROW + COL - 2;
  localparam int SETTLE_LEN = (SETTLE > MIN_SETTLE) ? SETTLE : MIN_SETTLE;
  localparam int TW         = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] ROW_LAST    = ADDR_W'(ROW - 1);
  localparam logic [ADDR_W-1:0] SETTLE_LAST = ADDR_W'(SETTLE_LEN - 1);
  localparam logic [TW-1:0]     IDLE_LAST   = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic              acc;
    logic              cen_p;
    logic              wen_p;
    logic [ADDR_W-1:0] a_p;
    logic              cen_x;
    logic              wen_x;
    logic [ADDR_W-1:0] a_x;
    logic              ofifo_rd;
    logic [1:0]        rsvd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_W, ST_SETTLE, ST_EXEC, ST_DRAIN, ST_DONE
  } state_t;

  // Both memories disabled and write-protected, every strobe low.
  localparam inst_t IDLE_WORD = '{cen_p: 1'b1, wen_p: 1'b1,
                                  cen_x: 1'b1, wen_x: 1'b1, default: '0};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;          // k / settle / i / j, per state
  logic [TW-1:0]     idle_q, idle_d;        // consecutive empty DRAIN cycles
  inst_t             inst_q, inst_d;
  logic              mode_q, mode_d, sel_q, sel_d, err_q, err_d;
  logic              acc_q, acc_d, pp_q, pp_d;
  logic [ADDR_W-1:0] nij_q, nij_d, w_base_q, w_base_d;
  logic [ADDR_W-1:0] x_base_q, x_base_d, p_base_q, p_base_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    inst_d   = IDLE_WORD;
    mode_d   = mode_q;
    sel_d    = sel_q;
    err_d    = err_q;
    acc_d    = acc_q;
    pp_d     = pp_q;
    nij_d    = nij_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    p_base_d = p_base_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nij_d    = cfg_nij;
          w_base_d = cfg_w_base;
          x_base_d = cfg_x_base;
          p_base_d = cfg_p_base;
          mode_d   = cfg_mode;
          acc_d    = cfg_acc;
          pp_d     = cfg_pingpong;
          err_d    = 1'b0;
          cnt_d    = '0;
          idle_d   = '0;
          state_d  = (cfg_nij == '0) ? ST_DONE : ST_LOAD_W;
        end
      end

      ST_LOAD_W: begin
        inst_d.cen_x = 1'b0;
        inst_d.a_x   = w_base_q + cnt_q;  // wraps modulo 2^ADDR_W
        inst_d.l0_wr = 1'b1;
        inst_d.load  = 1'b1;
        if (cnt_q == ROW_LAST) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_EXEC: begin
        inst_d.cen_x   = 1'b0;
        inst_d.a_x     = x_base_q + cnt_q;
        inst_d.l0_wr   = 1'b1;
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
        if (cnt_q == nij_q - 1'b1) begin
          cnt_d   = '0;
          idle_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        // acc stays on the bus for the whole drain, write or not.
        inst_d.acc = acc_q;
        if (ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          inst_d.cen_p    = 1'b0;
          inst_d.wen_p    = 1'b0;
          inst_d.a_p      = p_base_q + cnt_q;
          idle_d          = '0;
          if (cnt_q == nij_q - 1'b1) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          err_d   = 1'b1;
          idle_d  = '0;
          state_d = ST_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (pp_q) sel_d = ~sel_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idle_q   <= '0;
      inst_q   <= IDLE_WORD;
      mode_q   <= 1'b0;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= 1'b0;
      pp_q     <= 1'b0;
      nij_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      inst_q   <= inst_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      pp_q     <= pp_d;
      nij_q    <= nij_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
    end
  end

  assign inst        = inst_q;
  assign mode        = mode_q;
  assign sel         = sel_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_seq_ctrl
//   Directed bench for core_seq_ctrl (ROW=2, SETTLE=4, TIMEOUT=1023).
//   A vector table covers one full job cycle by cycle; hand-written
//   sequences cover address wrap, ping-pong, timeout, empty job and
//   mid-job reset.
// ---------------------------------------------------------------------------
module tb_core_seq_ctrl;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start, cfg_mode, cfg_acc, cfg_pingpong, ofifo_valid;
  logic [10:0] cfg_nij, cfg_w_base, cfg_x_base, cfg_p_base;
  logic [33:0] inst;
  logic        mode, sel, busy, done, err_timeout;

  int n_pass  = 0;
  int n_total = 0;

  logic [10:0] xa_q[$];
  logic [10:0] pa_q[$];

  core_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_nij(cfg_nij),
    .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_p_base(cfg_p_base),
    .cfg_mode(cfg_mode), .cfg_acc(cfg_acc), .cfg_pingpong(cfg_pingpong),
    .ofifo_valid(ofifo_valid), .inst(inst), .mode(mode), .sel(sel),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        valid;
    logic [33:0] exp_inst;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a job and observes it until busy drops or the bound expires.
  // At observation poke_at, start is re-pulsed and cfg changed mid-job.
  task automatic run_job(input int bound, input int poke_at, input logic exp_sel,
                         output int busy_n, output int done_n, output int pmem_n,
                         output int xmem_n, output int sel_bad, output logic err_at_done);
    logic [10:0] saved_nij, saved_p;
    saved_nij = cfg_nij;
    saved_p   = cfg_p_base;
    busy_n = 0; done_n = 0; pmem_n = 0; xmem_n = 0; sel_bad = 0; err_at_done = 1'b0;
    xa_q.delete();
    pa_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < bound && busy; c++) begin
      busy_n++;
      if (done) begin
        done_n++;
        err_at_done = err_timeout;
      end
      if (!inst[32]) begin
        pmem_n++;
        pa_q.push_back(inst[30:20]);
      end
      if (!inst[19]) xmem_n++;
      if (inst[1]) xa_q.push_back(inst[17:7]);
      if (sel !== exp_sel) sel_bad++;
      start = (c == poke_at);
      if (c == poke_at) begin
        cfg_nij    = cfg_nij + 11'd5;
        cfg_p_base = cfg_p_base + 11'd7;
      end
      tick();
    end
    start = 1'b0;
    check("job_terminates", busy, 0);
    cfg_nij    = saved_nij;
    cfg_p_base = saved_p;
  endtask

  initial begin
    int   busy_n, done_n, pmem_n, xmem_n, sel_bad, hits;
    logic err_d;

    // Hand-computed words: w_base=10, x_base=100, p_base=200, acc=1.
    vecs[0]  = '{1'b1, 1'b0, IDLE_W,           1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 34'h1_8004_0505,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 34'h1_8004_0585,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, IDLE_W,           1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, IDLE_W,           1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, IDLE_W,           1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, IDLE_W,           1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 34'h1_8004_320E,  1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 34'h1_8004_328E,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 34'h1_8004_330E,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 34'h1_8004_338E,  1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 34'h2_0C8C_0040,  1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 34'h3_800C_0000,  1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 34'h2_0C9C_0040,  1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 34'h2_0CAC_0040,  1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 34'h3_800C_0000,  1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 34'h2_0CBC_0040,  1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, IDLE_W,           1'b0, 1'b0};

    reset = 1'b0; start = 1'b1; ofifo_valid = 1'b0;
    cfg_nij = 11'd4; cfg_w_base = 11'd10; cfg_x_base = 11'd100; cfg_p_base = 11'd200;
    cfg_mode = 1'b1; cfg_acc = 1'b1; cfg_pingpong = 1'b0;

    // Reset held with start high: nothing advances.
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rst%0d_inst", c), inst, IDLE_W);
      check($sformatf("rst%0d_busy", c), busy, 0);
    end
    check("rst_mode", mode, 0);
    check("rst_sel", sel, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // Full job, cycle by cycle.
    for (int i = 0; i < 18; i++) begin
      start       = vecs[i].start;
      ofifo_valid = vecs[i].valid;
      tick();
      check($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
      if (i == 1) check("job_mode", mode, 1);
    end
    check("job_sel_after", sel, 0);

    // Address wrap on xmem and pmem.
    cfg_x_base = 11'd2046; cfg_p_base = 11'd2045; cfg_nij = 11'd4; cfg_acc = 1'b0;
    ofifo_valid = 1'b1;
    run_job(100, -1, 1'b0, busy_n, done_n, pmem_n, xmem_n, sel_bad, err_d);
    check("wrap_busy_cycles", busy_n, 15);
    check("wrap_x_count", xa_q.size(), 4);
    check("wrap_p_count", pa_q.size(), 4);
    if (xa_q.size() == 4 && pa_q.size() == 4) begin
      check("wrap_x0", xa_q[0], 2046);
      check("wrap_x1", xa_q[1], 2047);
      check("wrap_x2", xa_q[2], 0);
      check("wrap_x3", xa_q[3], 1);
      check("wrap_p0", pa_q[0], 2045);
      check("wrap_p3", pa_q[3], 0);
    end

    // Drain timeout: ofifo_valid stuck low.
    cfg_nij = 11'd2; ofifo_valid = 1'b0;
    run_job(2000, -1, 1'b0, busy_n, done_n, pmem_n, xmem_n, sel_bad, err_d);
    check("to_busy_cycles", busy_n, 2 + 4 + 2 + 1023 + 1);
    check("to_done_pulses", done_n, 1);
    check("to_err_at_done", err_d, 1);
    check("to_no_pmem", pmem_n, 0);
    check("to_err_sticky", err_timeout, 1);
    check("to_idle_inst", inst, IDLE_W);

    // Empty job: straight to DONE, clears the sticky error.
    cfg_nij = 11'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nij0_done", done, 1);
    check("nij0_busy", busy, 1);
    check("nij0_err_clr", err_timeout, 0);
    check("nij0_inst", inst, IDLE_W);
    tick();
    check("nij0_end_busy", busy, 0);
    check("nij0_end_done", done, 0);
    check("nij0_end_inst", inst, IDLE_W);

    // Ping-pong: two jobs, stray start and cfg edits during job 1.
    cfg_nij = 11'd1; cfg_pingpong = 1'b1; ofifo_valid = 1'b1;
    run_job(100, 2, 1'b0, busy_n, done_n, pmem_n, xmem_n, sel_bad, err_d);
    check("pp1_busy_cycles", busy_n, 9);
    check("pp1_done_pulses", done_n, 1);
    check("pp1_sel_stable", sel_bad, 0);
    check("pp1_pmem_writes", pmem_n, 1);
    if (pa_q.size() == 1) check("pp1_p_addr", pa_q[0], 2045);
    check("pp1_sel_after", sel, 1);
    run_job(100, -1, 1'b1, busy_n, done_n, pmem_n, xmem_n, sel_bad, err_d);
    check("pp2_busy_cycles", busy_n, 9);
    check("pp2_sel_stable", sel_bad, 0);
    check("pp2_sel_after", sel, 0);

    // Reset during EXEC aborts without a done pulse.
    cfg_nij = 11'd4; ofifo_valid = 1'b0; cfg_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hits = 0;
    for (int c = 0; c < 20 && !inst[1]; c++) tick();
    check("rx_reached_exec", inst[1], 1);
    check("rx_mode_latched", mode, 1);
    reset = 1'b0;
    tick();
    check("rx_inst", inst, IDLE_W);
    check("rx_busy", busy, 0);
    check("rx_mode", mode, 0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done || busy) hits++;
    end
    check("rx_no_done", hits, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Instruction sequencer that drives the core's 34-bit inst word, mode and sel for one convolution tile job.
- Phases of a job:
  - preload ROW weight rows from xmem into L0 and the array;
  - stream nij activation vectors;
  - drain the output FIFO into the selected psum SRAM bank.
- Sits between the testbench/host and core, replacing hand-written inst streams; consumes core's ofifo_valid.

Parameters:
- ROW, 2, array rows = weight vectors loaded per job
- COL, 2, array columns; sets weight settle gap
- ADDR_W, 11, xmem/pmem address width
- SETTLE, 4, idle cycles between weight load and execute (must be >= ROW+COL-2)
- TIMEOUT, 1023, max consecutive DRAIN cycles without ofifo_valid before error

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle job request; ignored unless state==IDLE
- cfg_nij  in  ADDR_W  activation vectors per job
- cfg_w_base  in  ADDR_W  xmem address of first weight row
- cfg_x_base  in  ADDR_W  xmem address of first activation
- cfg_p_base  in  ADDR_W  pmem address of first output
- cfg_mode  in  1  0: 2-bit, 1: 4-bit; latched at start
- cfg_acc  in  1  drives inst[33] during DRAIN; latched at start
- cfg_pingpong  in  1  1: toggle sel after each completed job
- ofifo_valid  in  1  core output FIFO has data
- inst  out  34  instruction word to core
- mode  out  1  latched cfg_mode
- sel  out  1  output bank select
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- err_timeout  out  1  sticky drain-timeout flag; cleared by next accepted start

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. All state is sampled on posedge clk.
- While reset==0, outputs take these values:
  - inst = IDLE word 34'h1_800C_0000 (CEN_pmem=WEN_pmem=CEN_xmem=WEN_xmem=1, all else 0);
  - mode=0, sel=0, busy=0, done=0, err_timeout=0;
  - all counters 0; state=IDLE.
- Reset asserted mid-job aborts the job immediately with no done pulse.
- inst is registered: the word for cycle n is visible one cycle after the state/counters that produce it. Each state emits its word for exactly its cycle count.
- Field map of inst:
  - [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem;
  - [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem;
  - [6] ofifo_rd; [5] 0; [4] 0; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
  - Unused fields take IDLE values.
- IDLE: inst=IDLE word.
  - On start: latch all cfg_*, clear err_timeout.
  - Go to LOAD_W, or to DONE if cfg_nij==0.
- LOAD_W, ROW cycles, k=0..ROW-1: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k, l0_wr=1, load=1. Then go to SETTLE.
- SETTLE, SETTLE cycles: IDLE word, load=0. Then go to EXEC.
- EXEC, nij cycles, i=0..nij-1: CEN_xmem=0, WEN_xmem=1, A_xmem=x_base+i, l0_wr=1, l0_rd=1, execute=1. Then go to DRAIN.
- DRAIN, until j==nij:
  - Each cycle with ofifo_valid==1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+j, acc=cfg_acc; then j++.
  - Cycles with ofifo_valid==0: IDLE word (acc held) and idle counter++.
  - idle counter resets on each valid.
  - If idle counter reaches TIMEOUT: set err_timeout=1 and go to DONE.
- DONE, 1 cycle: done=1, IDLE word. If cfg_pingpong=1, sel toggles on the exit edge. Then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; base+offset wraps (e.g. 2047+1 -> 0).
- start while busy is ignored; cfg changes mid-job have no effect.
- mode and sel are stable for the whole job. sel changes only on DONE exit or reset.

Test Plan:
- Reset low 3 cycles with start=1 -> inst=34'h1800C0000, busy=0, no state advance; release reset, start with nij=4, ROW=2, SETTLE=4 -> busy next cycle. Then 2 load words (A_xmem=w_base, w_base+1, inst[2:0]=3'b101), 4 idle words, 4 exec words (inst[3:1]=3'b111).
- Drain with ofifo_valid toggling 1,0,1,1,0,1 -> exactly 4 pmem writes at A_pmem=p_base..p_base+3, each with inst[6]=1. No writes on the 0 cycles; done pulses once.
- cfg_x_base=2046, nij=4 -> A_xmem sequence 2046, 2047, 0, 1.
- cfg_pingpong=1, two back-to-back jobs -> sel 0 during job 1, 1 during job 2, 0 after; start pulsed mid-job 1 has no effect.
- ofifo_valid held 0 in DRAIN -> err_timeout=1 after 1023 idle cycles, done pulses, IDLE. Next start clears err_timeout.
- nij=0 -> done one cycle after start, no xmem/pmem access; reset asserted during EXEC -> IDLE word next cycle, no done.
